sdram_line_reader: RTL and testbench

//   Replaces the sdram_to_vga_fifo test-pattern source. On each VGA line-load request, issues

---
 rtl/sdram_line_reader.sv | 117 +++++++++++
 tb/tb_sdram_line_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_reader.sv
// sdram_line_reader: fetches one VGA line from SDRAM over Avalon-MM and streams its bytes into vga_fifo
module sdram_line_reader #(
    parameter int          LINE_PIXELS = 1024,
    parameter int          FRAME_LINES = 768,
    parameter logic [24:0] BASE_ADDR   = 25'h0,
    parameter int          MAX_OUTST   = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iLOAD_REQ,
    input  logic [12:0] iLINE_ID,
    input  logic [3:0]  iFRAME,
    output logic        oRD_EN,
    output logic [24:0] oRD_ADDR,
    input  logic        iWAIT_REQUEST,
    input  logic [15:0] iRD_DATA,
    input  logic        iRD_DATAVALID,
    input  logic        iFIFO_AFULL,
    output logic        oWCLK,
    output logic [7:0]  oWDATA,
    output logic        oWEN,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oOVERRUN
);
    localparam int WPL = LINE_PIXELS / 2;
    localparam int FW  = WPL * FRAME_LINES;
    localparam int PW  = $clog2(MAX_OUTST);
    localparam int OW  = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t r_state, w_next;

    logic [2:0]    r_sync;
    logic [24:0]   r_base, r_wc;
    logic          r_hold;
    logic [OW-1:0] r_outst, r_cnt;
    logic [PW-1:0] r_wp, r_rp;
    logic [15:0]   r_mem [MAX_OUTST];
    logic          r_phase, r_wen, r_done, r_ovr;
    logic [7:0]    r_wdata;
    logic          w_start, w_can, w_acc, w_last, w_push, w_pop, w_drained;
    logic [24:0]   w_base;

    assign w_start   = r_sync[1] & ~r_sync[2];
    assign w_base    = BASE_ADDR + 25'(iFRAME) * 25'(FW) + 25'(iLINE_ID) * 25'(WPL);
    // in-flight reads plus buffered words never exceed the skid depth, so overflow is impossible
    assign w_can     = (r_outst < OW'(MAX_OUTST)) && !iFIFO_AFULL && (r_outst + r_cnt < OW'(MAX_OUTST));
    assign oRD_EN    = (r_state == ISSUE) && (r_hold || w_can);
    assign oRD_ADDR  = r_base + r_wc;
    assign w_acc     = oRD_EN && !iWAIT_REQUEST;
    assign w_last    = r_wc == 25'(WPL - 1);
    assign w_push    = iRD_DATAVALID && (r_outst != '0);
    assign w_pop     = (r_cnt != '0) && r_phase;
    assign w_drained = (r_outst == '0) && (r_cnt == '0);
    assign oWCLK     = iCLK;
    assign oWDATA    = r_wdata;
    assign oWEN      = r_wen;
    assign oBUSY     = r_state != IDLE;
    assign oDONE     = r_done;
    assign oOVERRUN  = r_ovr;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_start)           w_next = ISSUE;
        if (r_state == ISSUE && w_acc && w_last)  w_next = DRAIN;
        if (r_state == DRAIN && w_drained)        w_next = IDLE;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_sync  <= '0;
            r_base  <= '0;
            r_wc    <= '0;
            r_hold  <= 1'b0;
            r_outst <= '0;
            r_cnt   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_phase <= 1'b0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) r_mem[i] <= '0;
        end else begin
            r_sync  <= {r_sync[1:0], iLOAD_REQ};
            // Avalon requires a stalled request to stay asserted even if the issue condition lapses
            r_hold  <= oRD_EN && iWAIT_REQUEST;
            r_ovr   <= w_start && (r_state != IDLE);
            r_done  <= (r_state == DRAIN) && w_drained;
            if (r_state == IDLE && w_start) begin
                r_base <= w_base;
                r_wc   <= '0;
            end else if (w_acc) begin
                r_wc <= r_wc + 25'd1;
            end
            r_outst <= r_outst + OW'(w_acc) - OW'(w_push);
            if (w_push) begin
                r_mem[r_wp] <= iRD_DATA;
                r_wp        <= r_wp + 1'b1;
            end
            r_cnt <= r_cnt + OW'(w_push) - OW'(w_pop);
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_wen <= r_cnt != '0;
            if (r_cnt != '0) begin
                r_wdata <= r_phase ? r_mem[r_rp][15:8] : r_mem[r_rp][7:0];
                r_phase <= ~r_phase;
            end
        end
    end
endmodule

// File: tb/tb_sdram_line_reader.sv
// tb_sdram_line_reader: random Avalon slave plus line-level scoreboard for sdram_line_reader
module tb_sdram_line_reader;
    localparam int LP = 1024, FL = 768, MO = 8, WPL = LP / 2, FW = WPL * FL;

    logic        iCLK = 0, iRST = 1, iLOAD_REQ = 0, iWAIT_REQUEST = 0, iRD_DATAVALID = 0, iFIFO_AFULL = 0;
    logic [12:0] iLINE_ID = 0;
    logic [3:0]  iFRAME = 0;
    logic [15:0] iRD_DATA = 0;
    logic        oRD_EN, oWCLK, oWEN, oBUSY, oDONE, oOVERRUN;
    logic [24:0] oRD_ADDR;
    logic [7:0]  oWDATA;

    sdram_line_reader #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .BASE_ADDR(25'h0), .MAX_OUTST(MO)) dut (
        .iCLK(iCLK), .iRST(iRST), .iLOAD_REQ(iLOAD_REQ), .iLINE_ID(iLINE_ID), .iFRAME(iFRAME),
        .oRD_EN(oRD_EN), .oRD_ADDR(oRD_ADDR), .iWAIT_REQUEST(iWAIT_REQUEST), .iRD_DATA(iRD_DATA),
        .iRD_DATAVALID(iRD_DATAVALID), .iFIFO_AFULL(iFIFO_AFULL), .oWCLK(oWCLK), .oWDATA(oWDATA),
        .oWEN(oWEN), .oBUSY(oBUSY), .oDONE(oDONE), .oOVERRUN(oOVERRUN)
    );

    always #5 iCLK = ~iCLK;

    typedef struct { int due; logic [15:0] d; } rsp_t;
    rsp_t        rq[$];
    logic [24:0] exp_addr_q[$];
    logic [7:0]  exp_pix_q[$];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, last_due = 0, wait_pct = 0, lat_lo = 2, lat_hi = 2;
    int          acc_n = 0, val_n = 0, wen_n = 0, line_acc = 0, line_wr = 0, done_n = 0, ovr_n = 0;
    logic        prev_wait_en = 0;
    logic [24:0] prev_addr = 0, first_addr = 0, last_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_true(input string name, input bit cond, input int val);
        n_chk++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: value %0d out of bounds at cycle %0d", name, val, cyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        logic [31:0] x;
        x = 32'(a) * 32'h9E3779B1;
        return x[31:16] ^ a[15:0];
    endfunction

    // Avalon slave: random waitrequest, in-order responses with random latency
    initial forever begin
        int lat, due;
        @(negedge iCLK);
        cyc++;
        if (iRST) begin
            rq.delete();
            acc_n = 0; val_n = 0; wen_n = 0; last_due = 0; prev_wait_en = 0;
            iRD_DATAVALID = 0; iWAIT_REQUEST = 0;
            continue;
        end
        if (iRD_DATAVALID) val_n++;
        if (oWEN) wen_n++;
        chk_true("outstanding_le_max", acc_n - val_n <= MO, acc_n - val_n);
        chk_true("skid_no_overflow", val_n - wen_n / 2 <= MO, val_n - wen_n / 2);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            iRD_DATAVALID = 1;
            iRD_DATA = rq[0].d;
            void'(rq.pop_front());
        end else begin
            iRD_DATAVALID = 0;
            iRD_DATA = 16'($urandom);
        end
        iWAIT_REQUEST = ($urandom_range(99) < wait_pct);
        #1;
        if (prev_wait_en) begin
            chk("hold_rd_en", oRD_EN, 1);
            chk("hold_rd_addr", oRD_ADDR, prev_addr);
        end
        prev_wait_en = oRD_EN && iWAIT_REQUEST;
        prev_addr = oRD_ADDR;
        if (oRD_EN && !iWAIT_REQUEST) begin
            acc_n++; line_acc++;
            last_addr = oRD_ADDR;
            if (line_acc == 1) first_addr = oRD_ADDR;
            if (exp_addr_q.size() == 0) chk("unexpected_read_addr", oRD_ADDR, 25'h1ffffff);
            else chk("rd_addr", oRD_ADDR, exp_addr_q.pop_front());
            lat = $urandom_range(lat_hi, lat_lo);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            rq.push_back('{due, mem_word(oRD_ADDR)});
        end
    end

    // FIFO-side monitor: pops the scoreboard on every write
    initial forever begin
        @(negedge iCLK);
        if (oWEN) begin
            line_wr++;
            chk("wen_only_when_busy", oBUSY, 1);
            if (exp_pix_q.size() == 0) chk("unexpected_write", {24'h0, oWDATA}, 32'hffffffff);
            else chk("pixel", oWDATA, exp_pix_q.pop_front());
        end
        if (oDONE) begin
            done_n++;
            chk("done_scoreboard_empty", exp_pix_q.size(), 0);
        end
        if (oOVERRUN) ovr_n++;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_line(input int line, input int frame, input bit lat_chk);
        int b;
        logic [24:0] a;
        logic [15:0] d;
        b = frame * FW + line * WPL;
        for (int w = 0; w < WPL; w++) begin
            a = 25'(b + w);
            d = mem_word(a);
            exp_addr_q.push_back(a);
            exp_pix_q.push_back(d[7:0]);
            exp_pix_q.push_back(d[15:8]);
        end
        line_acc = 0; line_wr = 0;
        @(negedge iCLK);
        iLINE_ID = 13'(line); iFRAME = 4'(frame); iLOAD_REQ = 1;
        if (lat_chk) begin
            @(negedge iCLK); chk("start_lat_c1", oRD_EN, 0);
            @(negedge iCLK); chk("start_lat_c2", oRD_EN, 0);
            @(negedge iCLK); chk("start_lat_c3", oRD_EN, 1);
            repeat (3) @(negedge iCLK);
        end else begin
            repeat (6) @(negedge iCLK);
        end
        iLOAD_REQ = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0, k;
        d0 = done_n; k = 0;
        while (done_n == d0 && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        chk(name, done_n - d0, 1);
    endtask

    task automatic wait_pixels(input int n, input int budget);
        int k;
        k = 0;
        while (line_wr < n && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        chk_true("reached_pixel_count", line_wr >= n, line_wr);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, oRD_EN, 0);
        chk({tag, "_rd_addr"}, oRD_ADDR, 0);
        chk({tag, "_wen"}, oWEN, 0);
        chk({tag, "_wdata"}, oWDATA, 0);
        chk({tag, "_busy"}, oBUSY, 0);
        chk({tag, "_done"}, oDONE, 0);
        chk({tag, "_overrun"}, oOVERRUN, 0);
    endtask

    initial begin
        int d0, o0, en_hi, a0, ln, fr;
        repeat (3) @(negedge iCLK);
        check_outputs_zero("reset");
        chk("wclk_follows_clk", oWCLK, iCLK);
        iRST = 0;
        repeat (2) @(negedge iCLK);

        // line 0 of frame 0, no stalls, fixed latency 2
        start_line(0, 0, 1);
        wait_done("t1_done", 5000);
        chk("t1_writes", line_wr, LP);
        chk("t1_reads", line_acc, WPL);
        chk("t1_first_addr", first_addr, 0);
        chk("t1_last_addr", last_addr, 511);

        // frame/line address arithmetic
        start_line(5, 1, 0);
        wait_done("t2_done", 5000);
        chk("t2_writes", line_wr, LP);
        chk("t2_first_addr", first_addr, 395776);
        chk("t2_last_addr", last_addr, 396287);

        // random stalls and latency
        wait_pct = 50; lat_lo = 1; lat_hi = 10;
        for (int i = 0; i < 3; i++) begin
            ln = $urandom_range(FL - 1); fr = $urandom_range(15);
            start_line(ln, fr, 0);
            wait_done("t3_done", 20000);
            chk("t3_writes", line_wr, LP);
            chk("t3_reads", line_acc, WPL);
        end

        // FIFO almost-full backpressure mid-line
        wait_pct = 0; lat_lo = 1; lat_hi = 4;
        start_line(100, 2, 0);
        wait_pixels(300, 5000);
        iFIFO_AFULL = 1;
        en_hi = 0; a0 = line_acc;
        repeat (100) begin
            #1;
            if (oRD_EN) en_hi++;
            @(negedge iCLK);
        end
        chk("t4_rd_en_low_while_afull", en_hi, 0);
        chk("t4_no_accept_while_afull", line_acc - a0, 0);
        iFIFO_AFULL = 0;
        wait_done("t4_done", 5000);
        chk("t4_writes", line_wr, LP);

        // second request during a transfer is dropped
        wait_pct = 25; lat_lo = 1; lat_hi = 6;
        d0 = done_n; o0 = ovr_n;
        start_line(7, 3, 0);
        repeat (100) @(negedge iCLK);
        iLOAD_REQ = 1;
        repeat (6) @(negedge iCLK);
        iLOAD_REQ = 0;
        wait_done("t5_done", 20000);
        repeat (60) @(negedge iCLK);
        chk("t5_overrun_pulses", ovr_n - o0, 1);
        chk("t5_writes", line_wr, LP);
        chk("t5_single_done", done_n - d0, 1);
        chk("t5_idle_after", oBUSY, 0);

        // reset in the middle of a line, then a clean line
        wait_pct = 30; lat_lo = 1; lat_hi = 6;
        start_line(20, 4, 0);
        wait_pixels(200, 5000);
        @(negedge iCLK);
        #2 iRST = 1;
        #1 check_outputs_zero("midreset");
        exp_pix_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge iCLK);
        #2 iRST = 0;
        repeat (2) @(negedge iCLK);
        start_line(21, 4, 0);
        wait_done("t6_done", 20000);
        chk("t6_writes", line_wr, LP);
        chk("t6_first_addr", first_addr, 4 * FW + 21 * WPL);
        chk("t6_last_addr", last_addr, 4 * FW + 21 * WPL + WPL - 1);
        repeat (5) @(negedge iCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
